// File: rtl/digit_scan_pkg.sv
// Shared helpers for the digit scanner: width derivations and the Gray encoder.
package digit_scan_pkg;

  localparam int unsigned MaxSelW = 16;

  function automatic int unsigned sel_w(int unsigned n_digits);
    return (n_digits < 2) ? 1 : $clog2(n_digits);
  endfunction

  // The counter runs 0..div-1, so a single bit is enough when div is 1.
  function automatic int unsigned cnt_w(int unsigned div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

  function automatic logic [MaxSelW-1:0] bin2gray(logic [MaxSelW-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Dwell counter: counts enabled cycles and flags the cycle on which the digit advances.
module tick_gen
  import digit_scan_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic ena,
  output logic tick_o
);

  localparam int unsigned CNT_W = cnt_w(DIV);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DIV - 1);

  if (DIV < 1 || DIV > 65535) begin : gen_bad_div
    $fatal(1, "tick_gen: DIV must be within 1..65535");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = ena && (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (ena) begin
      cnt_d = tick_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Multiplexed display scanner: steps through digits, drives encoded select, one-hot enable
// and the active digit's data, all registered.
module digit_scan_ctrl
  import digit_scan_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned DIV      = 1,
  parameter int unsigned GRAY     = 1,
  parameter int unsigned DATA_W   = 4,
  localparam int unsigned SEL_W   = sel_w(N_DIGITS)
) (
  input  logic                       clk,
  input  logic                       rst_ni,
  input  logic                       ena,
  input  logic [N_DIGITS-1:0]        blank_i,
  input  logic [N_DIGITS*DATA_W-1:0] data_i,
  output logic [SEL_W-1:0]           sel_o,
  output logic [N_DIGITS-1:0]        digi_o,
  output logic [DATA_W-1:0]          data_o,
  output logic                       frame_o
);

  if (N_DIGITS < 2 || N_DIGITS > 16) begin : gen_bad_n
    $fatal(1, "digit_scan_ctrl: N_DIGITS must be within 2..16");
  end
  if (GRAY > 1) begin : gen_bad_gray
    $fatal(1, "digit_scan_ctrl: GRAY must be 0 or 1");
  end
  if (DATA_W < 1) begin : gen_bad_data_w
    $fatal(1, "digit_scan_ctrl: DATA_W must be at least 1");
  end

  localparam logic [SEL_W-1:0] LastIdx = SEL_W'(N_DIGITS - 1);

  logic                tick;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [N_DIGITS-1:0] digi_q, digi_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                frame_q, frame_d;
  logic [MaxSelW-1:0]  gray_full;
  logic                unused_gray_bits;

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst_ni (rst_ni),
    .ena    (ena),
    .tick_o (tick)
  );

  // Explicit wrap keeps non-power-of-two digit counts inside 0..N_DIGITS-1.
  always_comb begin
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == LastIdx) ? '0 : idx_q + SEL_W'(1);
    end
  end

  assign gray_full        = bin2gray(MaxSelW'(idx_d));
  assign unused_gray_bits = ^gray_full[MaxSelW-1:SEL_W];

  // Outputs are computed from the next index so they change on the advancing edge.
  always_comb begin
    sel_d   = (GRAY != 0) ? gray_full[SEL_W-1:0] : idx_d;
    frame_d = tick && (idx_q == LastIdx);
    digi_d  = '0;
    data_d  = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_d == SEL_W'(k) && !blank_i[k]) begin
        digi_d[k] = 1'b1;
        data_d    = data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q   <= '0;
      sel_q   <= '0;
      digi_q  <= N_DIGITS'(1);
      data_q  <= '0;
      frame_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      digi_q  <= digi_d;
      data_q  <= data_d;
      frame_q <= frame_d;
    end
  end

  assign sel_o   = sel_q;
  assign digi_o  = digi_q;
  assign data_o  = data_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Bench for digit_scan_ctrl: three configurations against a behavioural scan model,
// plus directed literal checks.
module tb_digit_scan_ctrl;

  localparam int unsigned MN    [3] = '{4, 4, 5};
  localparam int unsigned MDIV  [3] = '{1, 3, 1};
  localparam int unsigned MGRAY [3] = '{1, 1, 0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic [4:0]  blank = '0;
  logic [19:0] data = 20'h54321;

  logic [1:0] sel0, sel1;
  logic [2:0] sel2;
  logic [3:0] digi0, digi1;
  logic [4:0] digi2;
  logic [3:0] dat0, dat1, dat2;
  logic       frame0, frame1, frame2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  digit_scan_ctrl #(.N_DIGITS(4), .DIV(1), .GRAY(1), .DATA_W(4)) u_dut0 (
    .clk(clk), .rst_ni(rst_n), .ena(ena), .blank_i(blank[3:0]), .data_i(data[15:0]),
    .sel_o(sel0), .digi_o(digi0), .data_o(dat0), .frame_o(frame0)
  );
  digit_scan_ctrl #(.N_DIGITS(4), .DIV(3), .GRAY(1), .DATA_W(4)) u_dut1 (
    .clk(clk), .rst_ni(rst_n), .ena(ena), .blank_i(blank[3:0]), .data_i(data[15:0]),
    .sel_o(sel1), .digi_o(digi1), .data_o(dat1), .frame_o(frame1)
  );
  digit_scan_ctrl #(.N_DIGITS(5), .DIV(1), .GRAY(0), .DATA_W(4)) u_dut2 (
    .clk(clk), .rst_ni(rst_n), .ena(ena), .blank_i(blank), .data_i(data),
    .sel_o(sel2), .digi_o(digi2), .data_o(dat2), .frame_o(frame2)
  );

  logic [15:0] a_sel [3], a_digi [3];
  logic [3:0]  a_data [3];
  logic        a_frame [3];
  assign a_sel[0] = 16'(sel0);
  assign a_sel[1] = 16'(sel1);
  assign a_sel[2] = 16'(sel2);
  assign a_digi[0] = 16'(digi0);
  assign a_digi[1] = 16'(digi1);
  assign a_digi[2] = 16'(digi2);
  assign a_data[0] = dat0;
  assign a_data[1] = dat1;
  assign a_data[2] = dat2;
  assign a_frame[0] = frame0;
  assign a_frame[1] = frame1;
  assign a_frame[2] = frame2;

  task automatic check(input string nm, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, d, $time, act, exp);
    end
  endtask

  // Behavioural model: index/dwell as plain integers, outputs from the digit rules.
  int unsigned m_idx [3] = '{0, 0, 0};
  int unsigned m_cnt [3] = '{0, 0, 0};
  logic [15:0] e_sel [3] = '{0, 0, 0};
  logic [15:0] e_digi [3] = '{1, 1, 1};
  logic [3:0]  e_data [3] = '{0, 0, 0};
  logic        e_frame [3] = '{0, 0, 0};

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 3; d++) begin
      automatic int unsigned ni = m_idx[d];
      automatic int unsigned nc = m_cnt[d];
      automatic logic        fr = 1'b0;
      if (!rst_n) begin
        m_idx[d]   <= 0;
        m_cnt[d]   <= 0;
        e_sel[d]   <= '0;
        e_digi[d]  <= 16'd1;
        e_data[d]  <= '0;
        e_frame[d] <= 1'b0;
      end else begin
        if (ena) begin
          nc = nc + 1;
          if (nc == MDIV[d]) begin
            nc = 0;
            ni = (ni + 1) % MN[d];
            fr = (ni == 0);
          end
        end
        m_idx[d]   <= ni;
        m_cnt[d]   <= nc;
        e_frame[d] <= fr;
        e_sel[d]   <= (MGRAY[d] != 0) ? 16'(ni ^ (ni >> 1)) : 16'(ni);
        e_digi[d]  <= blank[ni] ? 16'd0 : 16'(32'd1 << ni);
        e_data[d]  <= blank[ni] ? 4'd0 : data[4*ni +: 4];
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      check("model_sel", d, 32'(a_sel[d]), 32'(e_sel[d]));
      check("model_digi", d, 32'(a_digi[d]), 32'(e_digi[d]));
      check("model_data", d, 32'(a_data[d]), 32'(e_data[d]));
      check("model_frame", d, 32'(a_frame[d]), 32'(e_frame[d]));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  logic [1:0] gseq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic [3:0] dseq [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  int first_pulse;
  int second_pulse;

  initial begin
    step();
    step();
    check("reset_sel", 0, 32'(sel0), 32'd0);
    check("reset_digi", 0, 32'(digi0), 32'b0001);
    check("reset_data", 0, 32'(dat0), 32'd0);
    check("reset_frame", 0, 32'(frame0), 32'd0);

    rst_n = 1'b1;
    ena   = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      check("seq_sel", 0, 32'(sel0), 32'(gseq[k % 4]));
      check("seq_digi", 0, 32'(digi0), 32'(dseq[k % 4]));
      check("seq_frame", 0, 32'(frame0), 32'((k % 4) == 0));
      check("seq5_sel", 2, 32'(sel2), 32'(k % 5));
    end

    // dut0 now at index 2: freeze the scan
    ena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("hold_sel", 0, 32'(sel0), 32'b11);
      check("hold_digi", 0, 32'(digi0), 32'b0100);
      check("hold_frame", 0, 32'(frame0), 32'd0);
    end
    ena = 1'b1;
    step();
    check("resume_sel", 0, 32'(sel0), 32'b10);

    blank = 5'b00100;
    step();
    check("blank_idx0_digi", 0, 32'(digi0), 32'b0001);
    step();
    check("blank_idx1_data", 0, 32'(dat0), 32'd2);
    check("blank_idx1_digi", 0, 32'(digi0), 32'b0010);
    step();
    check("blank_idx2_digi", 0, 32'(digi0), 32'b0000);
    check("blank_idx2_data", 0, 32'(dat0), 32'd0);
    check("blank_idx2_sel", 0, 32'(sel0), 32'b11);

    ena   = 1'b0;
    blank = 5'b00000;
    step();
    check("track_digi", 0, 32'(digi0), 32'b0100);
    check("track_data", 0, 32'(dat0), 32'd3);
    ena = 1'b1;
    step();
    check("pre_reset_sel", 0, 32'(sel0), 32'b10);

    #2;
    rst_n = 1'b0;
    #1;
    check("async_sel", 0, 32'(sel0), 32'd0);
    check("async_digi", 0, 32'(digi0), 32'b0001);
    check("async_frame", 0, 32'(frame0), 32'd0);
    check("async_data", 0, 32'(dat0), 32'd0);
    check("async_sel5", 2, 32'(sel2), 32'd0);
    step();
    check("held_reset_frame", 0, 32'(frame0), 32'd0);
    rst_n = 1'b1;
    step();
    check("release_sel", 0, 32'(sel0), 32'b01);
    check("release_frame", 0, 32'(frame0), 32'd0);
    check("div3_e1_sel", 1, 32'(sel1), 32'd0);
    step();
    check("div3_e2_sel", 1, 32'(sel1), 32'd0);
    step();
    check("div3_e3_sel", 1, 32'(sel1), 32'b01);

    first_pulse  = -1;
    second_pulse = -1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (frame1) begin
        if (first_pulse < 0) first_pulse = c;
        else if (second_pulse < 0) second_pulse = c;
      end
    end
    check("div3_frame_first", 1, 32'(first_pulse), 32'd9);
    check("div3_frame_period", 1, 32'(second_pulse - first_pulse), 32'd12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
